// File: rtl/umc_pkg.sv
// umc_pkg: shared types and constants for the unified memory controller.
//   state_e   : controller FSM states (IDLE / WAIT / DONE)
//   port_e    : requester select (PORT_IF = instruction fetch, PORT_D = data)
//   CNT_W     : width of the wait-state counter (WAIT_STATES is 0..15)
//   pick_port : arbitration rule, data first but fetch after a data completion
package umc_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  // Data normally wins; fetch wins a tie when data completed last so neither
  // port can starve. Only meaningful when at least one request is pending.
  function automatic port_e pick_port(input logic if_req, input logic d_req,
                                      input port_e last);
    port_e sel;
    if (d_req && !(if_req && (last == PORT_D))) begin
      sel = PORT_D;
    end else begin
      sel = PORT_IF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/unified_mem_ctrl_if.sv
// unified_mem_ctrl_if: CPU-side bus of the unified memory controller.
//   Fetch port : if_req, if_addr -> if_rdata, if_ready
//   Data port  : d_req, d_we, d_addr, d_wdata, d_be -> d_rdata, d_ready
//   master modport = CPU (drives requests), slave modport = controller.
interface unified_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_ready;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_ready;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
    input  if_rdata, if_ready, d_rdata, d_ready
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
    output if_rdata, if_ready, d_rdata, d_ready
  );

endinterface

// File: rtl/umc_ram.sv
// umc_ram: synchronous single-port word array with per-byte-lane strobes.
//   clk, rstn : clock, async active-low reset (read register only)
//   en, we    : access enable, 1 = write / 0 = read
//   idx       : word index
//   wdata, be : write data and lane strobes
//   q         : registered read data; zero after any cycle without a read
// The array itself is never reset.
module umc_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic                      we,
  input  logic [$clog2(DEPTH)-1:0]  idx,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       be,
  output logic [DATA_W-1:0]         q
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q_r;

  // Lane-strobed array write; held off while reset is asserted so an
  // abandoned transaction can never land.
  always_ff @(posedge clk) begin
    if (rstn && en && we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // Registered read port; returns zero unless a read happened this edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_r <= {DATA_W{1'b0}};
    end else if (en && !we) begin
      q_r <= mem[idx];
    end else begin
      q_r <= {DATA_W{1'b0}};
    end
  end

  assign q = q_r;

endmodule

// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: arbitrates an instruction-fetch port and a data port
// onto one umc_ram array, inserting WAIT_STATES extra cycles per access and
// pulsing a per-port ready for one cycle on completion.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : unified_mem_ctrl_if.slave (fetch and data request/response)
// Parameters: DATA_W (multiple of 8), ADDR_W, DEPTH (power of two),
//             WAIT_STATES (0..15).
// Build option: define UMC_BYTE_WRITE_EN to honour d_be on writes; when it
// is undefined every write updates the full word.
module unified_mem_ctrl
  import umc_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 2048,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  unified_mem_ctrl_if.slave    bus
);

  localparam int   BE_W    = DATA_W / 8;
  localparam int   OFF_W   = $clog2(BE_W);
  localparam int   IDX_W   = $clog2(DEPTH);
  localparam logic NO_WAIT = (WAIT_STATES == 0);

  state_e              state_r;
  port_e               port_r;
  port_e               last_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [IDX_W-1:0]    idx_r;
  logic                we_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [BE_W-1:0]     be_r;
  logic                if_ready_r;
  logic                d_ready_r;

  logic                req_any_s;
  port_e               grant_s;
  logic [ADDR_W-1:0]   new_addr_s;
  logic [IDX_W-1:0]    new_idx_s;
  logic                new_we_s;
  logic [DATA_W-1:0]   new_wdata_s;
  logic [BE_W-1:0]     new_be_s;

  logic                ram_en_s;
  logic                ram_we_s;
  logic [IDX_W-1:0]    ram_idx_s;
  logic [DATA_W-1:0]   ram_wdata_s;
  logic [BE_W-1:0]     ram_be_s;
  logic [DATA_W-1:0]   ram_q_s;

  // Arbitration and selection of the winning requester's fields.
  always_comb begin
    req_any_s = bus.if_req | bus.d_req;
    grant_s   = pick_port(bus.if_req, bus.d_req, last_r);
    if (grant_s == PORT_D) begin
      new_addr_s  = bus.d_addr;
      new_we_s    = bus.d_we;
      new_wdata_s = bus.d_wdata;
`ifdef UMC_BYTE_WRITE_EN
      new_be_s    = bus.d_be;
`else
      new_be_s    = {BE_W{1'b1}};
`endif
    end else begin
      new_addr_s  = bus.if_addr;
      new_we_s    = 1'b0;
      new_wdata_s = {DATA_W{1'b0}};
      new_be_s    = {BE_W{1'b0}};
    end
  end

  // Byte offset dropped, upper bits wrap modulo DEPTH.
  assign new_idx_s = new_addr_s[OFF_W +: IDX_W];

  // The array is accessed on the edge that enters DONE, so the registered
  // read data is on the bus during the DONE (ready) cycle. With zero wait
  // states that edge is the grant edge, so the live request is used.
  always_comb begin
    if (state_r == IDLE) begin
      ram_en_s    = req_any_s & NO_WAIT;
      ram_we_s    = new_we_s;
      ram_idx_s   = new_idx_s;
      ram_wdata_s = new_wdata_s;
      ram_be_s    = new_be_s;
    end else begin
      ram_en_s    = (state_r == WAIT) && (cnt_r == CNT_W'(1));
      ram_we_s    = we_r;
      ram_idx_s   = idx_r;
      ram_wdata_s = wdata_r;
      ram_be_s    = be_r;
    end
  end

  // Controller FSM: grant/latch, wait-state countdown, ready pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      port_r     <= PORT_IF;
      last_r     <= PORT_IF;
      cnt_r      <= {CNT_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      we_r       <= 1'b0;
      wdata_r    <= {DATA_W{1'b0}};
      be_r       <= {BE_W{1'b0}};
      if_ready_r <= 1'b0;
      d_ready_r  <= 1'b0;
    end else begin
      if_ready_r <= 1'b0;
      d_ready_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_any_s) begin
            port_r  <= grant_s;
            idx_r   <= new_idx_s;
            we_r    <= new_we_s;
            wdata_r <= new_wdata_s;
            be_r    <= new_be_s;
            cnt_r   <= CNT_W'(WAIT_STATES);
            if (NO_WAIT) begin
              state_r    <= DONE;
              if_ready_r <= (grant_s == PORT_IF);
              d_ready_r  <= (grant_s == PORT_D);
            end else begin
              state_r <= WAIT;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_r    <= DONE;
            if_ready_r <= (port_r == PORT_IF);
            d_ready_r  <= (port_r == PORT_D);
          end else begin
            state_r <= WAIT;
          end
        end
        DONE: begin
          last_r  <= port_r;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  umc_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .en    (ram_en_s),
    .we    (ram_we_s),
    .idx   (ram_idx_s),
    .wdata (ram_wdata_s),
    .be    (ram_be_s),
    .q     (ram_q_s)
  );

  // RAM read register is already zero after writes; steer it to the port
  // that owns the ready pulse.
  assign bus.if_ready = if_ready_r;
  assign bus.d_ready  = d_ready_r;
  assign bus.if_rdata = if_ready_r ? ram_q_s : {DATA_W{1'b0}};
  assign bus.d_rdata  = d_ready_r  ? ram_q_s : {DATA_W{1'b0}};

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// tb_unified_mem_ctrl: scoreboard bench for unified_mem_ctrl. Drivers push
// the expected response of each request into per-port queues using a word
// array reference model; a negedge monitor pops and compares on each ready.
module tb_unified_mem_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 2048;
  localparam int WS     = 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  unified_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  unified_mem_ctrl #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] if_exp_q [$];
  logic [31:0] d_exp_q  [$];
  int          order_q  [$];   // 1 = data completion, 0 = fetch
  int          time_q   [$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] addr);
    return int'((addr / 32'd4) % DEPTH);
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] wd,
                                      input logic [3:0] be);
    int w;
    w = widx(addr);
`ifdef UMC_BYTE_WRITE_EN
    for (int i = 0; i < 4; i++) begin
      if (be[i]) model[w][i*8 +: 8] = wd[i*8 +: 8];
    end
`else
    model[w] = wd;
`endif
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rstn) begin
      if (bus.if_ready || bus.d_ready) begin
        chk("both_ready", {31'd0, bus.if_ready & bus.d_ready}, 32'd0);
      end
      if (bus.if_ready) begin
        if (if_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_unexpected: got if_ready=1 expected no pending fetch");
        end else begin
          e = if_exp_q.pop_front();
          chk("if_rdata", bus.if_rdata, e);
        end
        order_q.push_back(0);
        time_q.push_back(cyc);
      end
      if (bus.d_ready) begin
        if (d_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_unexpected: got d_ready=1 expected no pending data access");
        end else begin
          e = d_exp_q.pop_front();
          chk("d_rdata", bus.d_rdata, e);
        end
        order_q.push_back(1);
        time_q.push_back(cyc);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the ready cycle.
  task automatic do_if(input logic [31:0] addr, output int lat);
    if_exp_q.push_back(model[widx(addr)]);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.if_ready) break;
    end
    if (!bus.if_ready) begin
      checks++; errors++;
      $display("FAIL if_timeout: got no if_ready expected one within 100 cycles");
      void'(if_exp_q.pop_back());
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0;
  endtask

  task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, output int lat);
    if (we) begin
      model_write(addr, wd, be);
      d_exp_q.push_back(32'd0);
    end else begin
      d_exp_q.push_back(model[widx(addr)]);
    end
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wd;
    bus.d_be    = be;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.d_ready) break;
    end
    if (!bus.d_ready) begin
      checks++; errors++;
      $display("FAIL d_timeout: got no d_ready expected one within 100 cycles");
      void'(d_exp_q.pop_back());
    end
    @(posedge clk); #1;
    bus.d_req = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr(input int word);
    return 32'(word * 4) + 32'($urandom_range(0, 3)) + (32'($urandom_range(0, 7)) << 13);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0;
    bus.d_wdata = 32'd0; bus.d_be = 4'h0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_if_ready", {31'd0, bus.if_ready}, 32'd0);
    chk("rst_d_ready",  {31'd0, bus.d_ready},  32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_d_rdata",  bus.d_rdata,  32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Fetch of word 0 with exact latency.
    do_d(1'b1, 32'h0, 32'h2001_0005, 4'hF, lat);
    do_if(32'h0, lat);
    chk("if_latency", lat, WS + 2);

    // Write then read back.
    do_d(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat);
    do_d(1'b0, 32'h10, 32'h0, 4'h0, lat);
    chk("d_latency", lat, WS + 2);

    // Byte-lane write.
    do_d(1'b1, 32'h20, 32'h1122_3344, 4'hF, lat);
    do_d(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, lat);
`ifdef UMC_BYTE_WRITE_EN
    chk("be_model", model[8], 32'h11BB_33DD);
`else
    chk("be_model", model[8], 32'hAABB_CCDD);
`endif
    do_d(1'b0, 32'h20, 32'h0, 4'hF, lat);

    // Address wrap: byte 0x2000 is word 0.
    do_d(1'b1, 32'h2000, 32'h5A5A_0F0F, 4'hF, lat);
    do_d(1'b0, 32'h0, 32'h0, 4'h0, lat);
    do_if(32'h2002, lat);

    // Preload words 0..127.
    for (int w = 0; w < 128; w++) begin
      do_d(1'b1, 32'(w * 4), $urandom, 4'hF, lat);
    end

    // Both ports held continuously: strict alternation starting with data.
    apply_reset();
    order_q.delete();
    time_q.delete();
    fork
      begin
        int la;
        for (int i = 0; i < 4; i++) do_d(1'b0, rand_addr(64 + i), 32'h0, 4'h0, la);
      end
      begin
        int lb;
        for (int i = 0; i < 4; i++) do_if(rand_addr(i), lb);
      end
    join
    chk("alt_count", order_q.size(), 8);
    n = (order_q.size() < 8) ? order_q.size() : 8;
    for (int i = 0; i < n; i++) begin
      chk("alt_order", order_q[i], (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i > 0) chk("alt_period", time_q[i] - time_q[i-1], WS + 2);
    end

    // Randomised concurrent traffic: fetch reads 0..63, data 64..127.
    fork
      begin
        int la;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          do_if(rand_addr($urandom_range(0, 63)), la);
        end
      end
      begin
        int lb;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          do_d(1'($urandom_range(0, 1)), rand_addr(64 + $urandom_range(0, 63)),
               $urandom, 4'($urandom_range(0, 15)), lb);
        end
      end
    join

    // Reset during WAIT of a write: abandoned, word unchanged.
    do_d(1'b1, 32'h40, 32'h5555_AAAA, 4'hF, lat);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40;
    bus.d_wdata = 32'h1234_5678; bus.d_be = 4'hF;
    @(posedge clk); #1;
    rstn = 1'b0;
    bus.d_req = 1'b0;
    #1;
    chk("abort_d_ready",  {31'd0, bus.d_ready},  32'd0);
    chk("abort_if_ready", {31'd0, bus.if_ready}, 32'd0);
    chk("abort_d_rdata",  bus.d_rdata, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold_ready", {31'd0, bus.d_ready}, 32'd0);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    do_d(1'b0, 32'h40, 32'h0, 4'h0, lat);

    repeat (3) @(negedge clk);
    chk("if_q_empty", if_exp_q.size(), 32'd0);
    chk("d_q_empty",  d_exp_q.size(),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unified_mem_ctrl.md
# unified_mem_ctrl

Parametrised single-port unified memory controller that replaces separate instruction and data memories behind the single-cycle CPU top. It arbitrates an instruction-fetch port and a data port onto one storage array, inserts a configurable number of wait states, and signals completion with a per-port ready pulse so the CPU can stall. It sits between `cpu` and the storage inside the computer top, in place of direct `imem`/`dmem` wiring.

## Interface
- `DATA_W`, 32: word width in bits; multiple of 8.
- `ADDR_W`, 32: byte-address width on both ports.
- `DEPTH`, 2048: number of words in the array; power of two.
- `WAIT_STATES`, 1: extra cycles per access, 0..15.
- `clk`  in  1: single clock, rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `if_req`  in  1: fetch request; held until `if_ready`.
- `if_addr`  in  ADDR_W: fetch byte address.
- `if_rdata`  out  DATA_W: fetched word, valid while `if_ready`=1.
- `if_ready`  out  1: one-cycle fetch completion pulse.
- `d_req`  in  1: data request; held until `d_ready`.
- `d_we`  in  1: 1 = write, 0 = read.
- `d_addr`  in  ADDR_W: data byte address.
- `d_wdata`  in  DATA_W: write data.
- `d_be`  in  DATA_W/8: byte-lane strobes (see Configuration).
- `d_rdata`  out  DATA_W: read word, valid while `d_ready`=1.
- `d_ready`  out  1: one-cycle data completion pulse (reads and writes).

## Operation
- Word index = `addr >> log2(DATA_W/8)`, taken modulo DEPTH (upper bits wrap); low byte-offset bits ignored.
- FSM states: IDLE, WAIT, DONE.
- IDLE: if any request pending, grant one port, latch its address/we/wdata/be, load wait counter with WAIT_STATES; go to WAIT if WAIT_STATES>0, else DONE.
- WAIT: decrement counter; at 1 go to DONE.
- DONE: perform array access (write or read), pulse the granted port's ready with read data; return to IDLE.
- Arbitration with both requests pending in IDLE: data wins, except when the previous completed transaction was data and `if_req` is pending — then fetch wins (alternation, no starvation). Single pending request always granted.
- Requester signals are sampled only at grant; changes while in WAIT/DONE are ignored.
- A request still high in the cycle after its ready pulse is a new request.
- Writes return `d_rdata` = 0 at `d_ready`.

## Timing
- Reset: FSM IDLE, `if_ready`=0, `d_ready`=0, `if_rdata`=0, `d_rdata`=0, last-winner = fetch. Array contents not reset.
- Latency: grant in cycle T (IDLE), ready asserted in cycle T+1+WAIT_STATES; rdata registered, valid only during that cycle.
- Back-to-back throughput: one transaction per WAIT_STATES+2 cycles.
- Read after write to same word in the next transaction returns the new data.
- Reset asserted mid-transaction: transaction abandoned, no write performed if not yet in DONE edge, outputs to reset values immediately.
- Ready pulses never both high in one cycle.

## Configuration
- `UMC_BYTE_WRITE_EN` defined: only lanes with `d_be[i]`=1 are written; lanes with 0 retain contents. Reads ignore `d_be`.
- Not defined: `d_be` ignored; every write updates the full word.

## Structure
- Package `umc_pkg`: FSM state enum (IDLE/WAIT/DONE), port-select enum (PORT_IF/PORT_D), wait-counter width constant (4).
- Sub-module `umc_ram`: synchronous single-port array with write enable, per-lane strobes and registered read; controller holds FSM, arbiter, latches and counter.

## Test plan
- Reset then `if_req` addr 0x0 with word 0 = 0x2001_0005, WAIT_STATES=1 -> `if_ready` and `if_rdata`=0x2001_0005 exactly 2 cycles after grant.
- `d_req` write 0xDEAD_BEEF to 0x10, then read 0x10 -> read returns 0xDEAD_BEEF; write `d_ready` shows `d_rdata`=0.
- Both requests held continuously -> completions alternate D, IF, D, IF; never both ready in one cycle.
- With `UMC_BYTE_WRITE_EN`: word 0x1122_3344, write 0xAABB_CCDD with `d_be`=4'b0101 -> read 0x11BB_33DD; without macro -> 0xAABB_CCDD.
- Address wrap: DEPTH=2048, write to byte 0x2000 then read byte 0x0 -> same word returned.
- Assert `rstn` low during WAIT of a write -> ready stays 0, target word unchanged on later read.
